// File: rtl/cam_fifo_byte_packetizer_if.sv
// Camera FIFO read port plus UDP app byte stream, grouped for the packetizer.
// master: packetizer side; slave: FIFO/sink environment side.
interface cam_fifo_byte_packetizer_if #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned USEDW_W = 9
);
    logic [USEDW_W-1:0] fifo_rd_usedw;
    logic [WORD_W-1:0]  fifo_dout;
    logic               fifo_re;
    logic               app_ready;
    logic [7:0]         app_data;
    logic               app_valid;
    logic               app_sof;
    logic               app_eof;
    logic [15:0]        app_length;

    modport master (
        input  fifo_rd_usedw, fifo_dout, app_ready,
        output fifo_re, app_data, app_valid, app_sof, app_eof, app_length
    );

    modport slave (
        output fifo_rd_usedw, fifo_dout, app_ready,
        input  fifo_re, app_data, app_valid, app_sof, app_eof, app_length
    );
endinterface

// File: rtl/cam_fifo_byte_packetizer.sv
// Reads whole packets of camera words from a normal-mode FIFO and serialises
// them into a framed valid/ready byte stream with a constant payload length.
module cam_fifo_byte_packetizer #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned USEDW_W   = 9,
    parameter int unsigned PKT_WORDS = 256,
    parameter bit          BIG_END   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    cam_fifo_byte_packetizer_if.master bus,
    output logic        pkt_done,
    output logic [15:0] pkt_cnt
);
    localparam int unsigned BPW     = WORD_W / 8;
    localparam int unsigned N_BYTES = PKT_WORDS * BPW;
    localparam int unsigned TX_W    = $clog2(N_BYTES + 1);
    localparam int unsigned RD_W    = $clog2(PKT_WORDS + 1);
    localparam int unsigned BI_W    = $clog2(BPW);

    localparam logic [TX_W-1:0]    LAST_TX = TX_W'(N_BYTES - 1);
    localparam logic [RD_W-1:0]    PKT_RD  = RD_W'(PKT_WORDS);
    localparam logic [BI_W-1:0]    LAST_BI = BI_W'(BPW - 1);
    localparam logic [USEDW_W-1:0] THRESH  = USEDW_W'(PKT_WORDS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic              sr_full_q, sr_full_d;
    logic [BI_W-1:0]   bi_q, bi_d;
    logic [WORD_W-1:0] nx_q, nx_d;
    logic              nx_full_q, nx_full_d;
    logic              re_q, re_d;
    logic              rd_vld_q, rd_vld_d;
    logic [RD_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [TX_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic              sof_q, sof_d;
    logic              eof_q, eof_d;
    logic              done_q, done_d;
    logic [15:0]       pkt_cnt_q, pkt_cnt_d;

    logic              accept;
    logic              rd_busy;
    logic              can_read;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            sr_full_q <= 1'b0;
            bi_q      <= '0;
            nx_q      <= '0;
            nx_full_q <= 1'b0;
            re_q      <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_cnt_q  <= '0;
            tx_cnt_q  <= '0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            done_q    <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            sr_full_q <= sr_full_d;
            bi_q      <= bi_d;
            nx_q      <= nx_d;
            nx_full_q <= nx_full_d;
            re_q      <= re_d;
            rd_vld_q  <= rd_vld_d;
            rd_cnt_q  <= rd_cnt_d;
            tx_cnt_q  <= tx_cnt_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            done_q    <= done_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        sr_full_d = sr_full_q;
        bi_d      = bi_q;
        nx_d      = nx_q;
        nx_full_d = nx_full_q;
        re_d      = 1'b0;
        rd_vld_d  = re_q;
        rd_cnt_d  = rd_cnt_q;
        tx_cnt_d  = tx_cnt_q;
        done_d    = 1'b0;
        pkt_cnt_d = pkt_cnt_q;

        accept   = sr_full_q && bus.app_ready;
        // A read is outstanding from the fifo_re cycle until its data cycle.
        rd_busy  = re_q || rd_vld_q;
        can_read = !nx_full_q && !rd_busy && (rd_cnt_q < PKT_RD);

        unique case (state_q)
            IDLE: begin
                if (bus.fifo_rd_usedw >= THRESH && can_read) begin
                    state_d  = RUN;
                    re_d     = 1'b1;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (can_read) begin
                    re_d     = 1'b1;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end

                if (accept) begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                    if (bi_q == LAST_BI) begin
                        bi_d      = '0;
                        sr_full_d = nx_full_q;
                        nx_full_d = 1'b0;
                        if (nx_full_q) begin
                            sr_d = nx_q;
                        end
                    end else begin
                        bi_d = bi_q + 1'b1;
                        sr_d = BIG_END ? {sr_q[WORD_W-9:0], 8'h00}
                                       : {8'h00, sr_q[WORD_W-1:8]};
                    end
                end

                // sr_full_d already reflects a drain on this edge, so a word
                // landing as SR empties goes straight into SR.
                if (rd_vld_q) begin
                    if (!sr_full_d) begin
                        sr_d      = bus.fifo_dout;
                        sr_full_d = 1'b1;
                        bi_d      = '0;
                    end else begin
                        nx_d      = bus.fifo_dout;
                        nx_full_d = 1'b1;
                    end
                end

                if (accept && tx_cnt_q == LAST_TX) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    pkt_cnt_d = pkt_cnt_q + 1'b1;
                    tx_cnt_d  = '0;
                    rd_cnt_d  = '0;
                    sr_full_d = 1'b0;
                    nx_full_d = 1'b0;
                    re_d      = 1'b0;
                end
            end
        endcase

        if (flush) begin
            state_d   = IDLE;
            sr_d      = '0;
            sr_full_d = 1'b0;
            bi_d      = '0;
            nx_d      = '0;
            nx_full_d = 1'b0;
            re_d      = 1'b0;
            rd_vld_d  = 1'b0;
            rd_cnt_d  = '0;
            tx_cnt_d  = '0;
            done_d    = 1'b0;
            pkt_cnt_d = pkt_cnt_q;
        end

        sof_d = sr_full_d && (tx_cnt_d == '0);
        eof_d = sr_full_d && (tx_cnt_d == LAST_TX);
    end

    assign bus.fifo_re    = re_q;
    assign bus.app_valid  = sr_full_q;
    assign bus.app_data   = BIG_END ? sr_q[WORD_W-1 -: 8] : sr_q[7:0];
    assign bus.app_sof    = sof_q;
    assign bus.app_eof    = eof_q;
    assign bus.app_length = 16'(N_BYTES);
    assign pkt_done       = done_q;
    assign pkt_cnt        = pkt_cnt_q;
endmodule

// File: tb/tb_cam_fifo_byte_packetizer.sv
// Directed bench: FIFO model feeding big- and little-endian packetizers in
// lockstep, with a byte scoreboard checked on every valid output cycle.
module tb_cam_fifo_byte_packetizer;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned USEDW_W   = 9;
  localparam int unsigned PKT_WORDS = 4;
  localparam int unsigned NB        = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        pkt_done, pkt_done_le;
  logic [15:0] pkt_cnt, pkt_cnt_le;

  always #5 clk = ~clk;

  cam_fifo_byte_packetizer_if #(.WORD_W(WORD_W), .USEDW_W(USEDW_W)) bus ();
  cam_fifo_byte_packetizer_if #(.WORD_W(WORD_W), .USEDW_W(USEDW_W)) bus_le ();

  cam_fifo_byte_packetizer #(
    .WORD_W(WORD_W), .USEDW_W(USEDW_W), .PKT_WORDS(PKT_WORDS), .BIG_END(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
    .pkt_done(pkt_done), .pkt_cnt(pkt_cnt)
  );

  cam_fifo_byte_packetizer #(
    .WORD_W(WORD_W), .USEDW_W(USEDW_W), .PKT_WORDS(PKT_WORDS), .BIG_END(1'b0)
  ) dut_le (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_le),
    .pkt_done(pkt_done_le), .pkt_cnt(pkt_cnt_le)
  );

  assign bus_le.fifo_rd_usedw = bus.fifo_rd_usedw;
  assign bus_le.fifo_dout     = bus.fifo_dout;
  assign bus_le.app_ready     = bus.app_ready;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [WORD_W-1:0] mem[$];
  logic [7:0]        exp_be[$];
  logic [7:0]        exp_le[$];
  int  idx = 0, acc = 0, re_cnt = 0, done_cnt = 0, eof_cnt = 0;
  int  cyc = 0, eof_cyc = 0, sof_cyc = 0, gap = 0;
  bit  stall = 1'b0;
  bit  rand_mode = 1'b0;

  // Normal-mode FIFO: data appears the cycle after the read request.
  always @(posedge clk) begin
    if (!rst_n || flush) begin
      mem.delete();
    end else if (bus.fifo_re && mem.size() > 0) begin
      bus.fifo_dout <= mem.pop_front();
    end
    bus.fifo_rd_usedw <= USEDW_W'(mem.size());
  end

  initial begin
    bus.app_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.app_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst_n || flush) begin
      exp_be.delete();
      exp_le.delete();
      idx   = 0;
      stall = 1'b0;
    end else begin
      if (bus.fifo_re) re_cnt++;
      if (pkt_done) done_cnt++;
      if (stall) chk("hold_valid", bus.app_valid, 1'b1);
      if (bus.app_valid) begin
        chk("sb_nonempty", exp_be.size() > 0, 1'b1);
        chk("data_be", bus.app_data, (exp_be.size() > 0 ? exp_be[0] : 8'h00));
        chk("data_le", bus_le.app_data, (exp_le.size() > 0 ? exp_le[0] : 8'h00));
        chk("valid_le", bus_le.app_valid, 1'b1);
        chk("sof", bus.app_sof, (idx == 0));
        chk("eof", bus.app_eof, (idx == NB - 1));
        if (bus.app_ready) begin
          if (exp_be.size() > 0) void'(exp_be.pop_front());
          if (exp_le.size() > 0) void'(exp_le.pop_front());
          acc++;
          if (idx == 0) begin
            sof_cyc = cyc;
            gap     = cyc - eof_cyc - 1;
          end
          if (idx == NB - 1) begin
            eof_cnt++;
            eof_cyc = cyc;
          end
          idx = (idx == NB - 1) ? 0 : idx + 1;
        end
      end
      stall = bus.app_valid && !bus.app_ready;
    end
  end

  task automatic push_word(input logic [WORD_W-1:0] w);
    mem.push_back(w);
    for (int unsigned i = 0; i < 4; i++) begin
      exp_be.push_back(w[31 - 8*i -: 8]);
      exp_le.push_back(w[8*i +: 8]);
    end
  endtask

  task automatic wait_done(input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (pkt_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_acc(input int target, input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (acc >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_re"}, bus.fifo_re, 1'b0);
    chk({tag, "_valid"}, bus.app_valid, 1'b0);
    chk({tag, "_sof"}, bus.app_sof, 1'b0);
    chk({tag, "_eof"}, bus.app_eof, 1'b0);
    chk({tag, "_data"}, bus.app_data, 8'h00);
    chk({tag, "_done"}, pkt_done, 1'b0);
    chk({tag, "_cnt"}, pkt_cnt, 16'h0000);
    chk({tag, "_len"}, bus.app_length, 16'd16);
  endtask

  initial begin
    bit ok;
    bit seen;
    int a0, e0, d0, r0;

    rst_n = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Threshold and latency, then byte ordering.
    push_word(32'h11223344);
    push_word(32'h55667788);
    push_word(32'h99AABBCC);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.fifo_re) seen = 1'b1;
    end
    chk("below_thresh_re", seen, 1'b0);
    push_word(32'hDDEEFF00);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("lat_re_k1", bus.fifo_re, 1'b1);
    chk("lat_valid_k1", bus.app_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_re_k2", bus.fifo_re, 1'b0);
    chk("lat_valid_k2", bus.app_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_valid_k3", bus.app_valid, 1'b1);
    chk("lat_sof_k3", bus.app_sof, 1'b1);
    chk("lat_data_k3", bus.app_data, 8'h11);
    chk("lat_data_le_k3", bus_le.app_data, 8'h44);
    wait_done(60, ok);
    chk("order_done", ok, 1'b1);
    chk("order_pkt_cnt", pkt_cnt, 16'd1);
    chk("order_no_bubble", eof_cyc - sof_cyc, NB - 1);
    chk("order_sb_empty", exp_be.size(), 0);

    // Pseudo-random backpressure.
    r0 = re_cnt;
    rand_mode = 1'b1;
    for (int unsigned i = 0; i < 4; i++) push_word($urandom);
    wait_done(400, ok);
    rand_mode = 1'b0;
    chk("bp_done", ok, 1'b1);
    chk("bp_re_pulses", re_cnt - r0, 4);
    chk("bp_pkt_cnt", pkt_cnt, 16'd2);
    chk("bp_sb_empty", exp_be.size(), 0);

    // Flush after the sixth byte.
    repeat (3) @(posedge clk);
    #1;
    for (int unsigned i = 0; i < 4; i++) push_word($urandom);
    a0 = acc;
    wait_acc(a0 + 6, 60, ok);
    chk("flush_reach_b6", ok, 1'b1);
    e0 = eof_cnt;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_valid", bus.app_valid, 1'b0);
    chk("flush_eof", bus.app_eof, 1'b0);
    chk("flush_re", bus.fifo_re, 1'b0);
    chk("flush_pkt_cnt", pkt_cnt, 16'd2);
    repeat (10) @(posedge clk);
    #1;
    chk("flush_no_eof", eof_cnt, e0);
    chk("flush_idle", bus.app_valid, 1'b0);
    for (int unsigned i = 0; i < 4; i++) push_word($urandom);
    wait_done(60, ok);
    chk("post_flush_done", ok, 1'b1);
    chk("post_flush_pkt_cnt", pkt_cnt, 16'd3);

    // Reset in the middle of a packet.
    repeat (3) @(posedge clk);
    #1;
    for (int unsigned i = 0; i < 4; i++) push_word($urandom);
    a0 = acc;
    wait_acc(a0 + 5, 60, ok);
    chk("rst_reach_b5", ok, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back packets across the pkt_cnt wrap.
    force dut.pkt_cnt_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.pkt_cnt_q;
    chk("wrap_preload", pkt_cnt, 16'hFFFF);
    d0 = done_cnt;
    r0 = re_cnt;
    for (int unsigned i = 0; i < 8; i++) push_word($urandom);
    wait_done(100, ok);
    chk("b2b_done1", ok, 1'b1);
    chk("wrap_cnt0", pkt_cnt, 16'h0000);
    wait_done(100, ok);
    chk("b2b_done2", ok, 1'b1);
    chk("wrap_cnt1", pkt_cnt, 16'h0001);
    chk("b2b_gap", gap, 3);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_done_pulses", done_cnt - d0, 2);
    chk("b2b_re_pulses", re_cnt - r0, 8);
    chk("b2b_sb_empty", exp_be.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
